// File: rtl/hdlc_mon_pkg.sv
// Shared types and constants for the HDLC line monitor.
// Imported by the per-channel monitor and the top level.
package hdlc_mon_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    SYNC  = 2'd1,
    FRAME = 2'd2
  } link_state_t;

  localparam logic [7:0] FLAG_PATTERN = 8'h7E;
  localparam int ABORT_ONES = 7;
  localparam int RUN_MAX = 15;

  typedef struct packed {
    logic flag;
    logic abort;
    logic stuff;
    logic idle;
  } mon_ev_t;

endpackage

// File: rtl/hdlc_line_monitor_channel.sv
// One serial line: bit history, link FSM, two-stage event pipeline
// and saturating error/abort counters.
module hdlc_mon_channel
  import hdlc_mon_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int IDLE_LEN  = 8,
  parameter int STUFF_LEN = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             valid_frame,
  input  logic             aborted_trans,
  output logic             flag_detect,
  output logic             abort_detect,
  output logic             idle_detect,
  output logic             stuff_err,
  output link_state_t      link_state,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] abort_cnt
);

  logic [7:0]       shift8;
  logic [7:0]       shift_next;
  logic [3:0]       ones_run;
  logic [3:0]       ones_next;
  logic [3:0]       since;
  logic [3:0]       since_next;
  link_state_t      state_next;
  logic             sample;
  mon_ev_t          ev_now;
  mon_ev_t          ev_q;
  mon_ev_t          ev_p1;
  mon_ev_t          ev_out;
  logic [CNT_W-1:0] cnt_max;

  assign sample  = enable & bit_valid;
  assign cnt_max = '1;

  always_comb begin
    shift_next = shift8;
    ones_next  = ones_run;
    if (sample) begin
      shift_next = {shift8[6:0], bit_in};
      if (!bit_in)
        ones_next = 4'd0;
      else if (ones_run != 4'(RUN_MAX))
        ones_next = ones_run + 4'd1;
    end
  end

  // Events are judged on the run length before this bit is counted.
  always_comb begin
    ev_now       = '0;
    ev_now.flag  = sample && (shift_next == FLAG_PATTERN);
    ev_now.abort = sample && bit_in
                   && (ones_run == 4'(ABORT_ONES - 1))
                   && (link_state != HUNT);
    ev_now.stuff = sample && valid_frame && !aborted_trans
                   && bit_in && (ones_run == 4'(STUFF_LEN));
    ev_now.idle  = enable && (ones_next >= 4'(IDLE_LEN));
  end

  always_comb begin
    state_next = link_state;
    since_next = since;
    unique case (1'b1)
      !enable: begin
        state_next = HUNT;
        since_next = '0;
      end
      ev_now.flag: begin
        state_next = SYNC;
        since_next = '0;
      end
      ev_now.abort: state_next = HUNT;
      default: begin
        if (sample && link_state == SYNC) begin
          since_next = since + 4'd1;
          if (since_next == 4'd8)
            state_next = FRAME;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      link_state <= HUNT;
      since      <= '0;
    end else begin
      link_state <= state_next;
      since      <= since_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      shift8   <= '0;
      ones_run <= '0;
      ev_q     <= '0;
      ev_p1    <= '0;
      ev_out   <= '0;
    end else begin
      shift8   <= shift_next;
      ones_run <= ones_next;
      ev_q     <= ev_now;
      ev_p1    <= ev_q;
      ev_out   <= ev_p1;
    end
  end

  // Counters step on the edge that registers the output pulse.
  always_ff @(posedge clk) begin
    if (rst || clear)
      err_cnt <= '0;
    else if (enable && ev_p1.stuff && err_cnt != cnt_max)
      err_cnt <= err_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || clear)
      abort_cnt <= '0;
    else if (enable && ev_p1.abort && abort_cnt != cnt_max)
      abort_cnt <= abort_cnt + 1'b1;
  end

  assign flag_detect  = ev_out.flag;
  assign abort_detect = ev_out.abort;
  assign stuff_err    = ev_out.stuff;
  assign idle_detect  = ev_out.idle;

endmodule

// File: rtl/hdlc_line_monitor.sv
// Multi-channel HDLC line monitor: one hdlc_mon_channel per line
// with the per-channel results packed onto flat status ports.
module hdlc_line_monitor
  import hdlc_mon_pkg::*;
#(
  parameter int NUM_CH    = 1,
  parameter int CNT_W     = 16,
  parameter int IDLE_LEN  = 8,
  parameter int STUFF_LEN = 5
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [NUM_CH-1:0]       Enable,
  input  logic [NUM_CH-1:0]       Clear,
  input  logic [NUM_CH-1:0]       BitIn,
  input  logic [NUM_CH-1:0]       BitValid,
  input  logic [NUM_CH-1:0]       ValidFrame,
  input  logic [NUM_CH-1:0]       AbortedTrans,
  output logic [NUM_CH-1:0]       FlagDetect,
  output logic [NUM_CH-1:0]       AbortDetect,
  output logic [NUM_CH-1:0]       IdleDetect,
  output logic [NUM_CH-1:0]       StuffErr,
  output logic [2*NUM_CH-1:0]     LinkState,
  output logic [CNT_W*NUM_CH-1:0] ErrCnt,
  output logic [CNT_W*NUM_CH-1:0] AbortCnt
);

  if (IDLE_LEN < 8 || IDLE_LEN > 15) begin : g_bad_idle_len
    $error("IDLE_LEN must lie in 8..15");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    link_state_t state;

    hdlc_mon_channel #(
      .CNT_W    (CNT_W),
      .IDLE_LEN (IDLE_LEN),
      .STUFF_LEN(STUFF_LEN)
    ) u_ch (
      .clk          (Clk),
      .rst          (Rst),
      .enable       (Enable[i]),
      .clear        (Clear[i]),
      .bit_in       (BitIn[i]),
      .bit_valid    (BitValid[i]),
      .valid_frame  (ValidFrame[i]),
      .aborted_trans(AbortedTrans[i]),
      .flag_detect  (FlagDetect[i]),
      .abort_detect (AbortDetect[i]),
      .idle_detect  (IdleDetect[i]),
      .stuff_err    (StuffErr[i]),
      .link_state   (state),
      .err_cnt      (ErrCnt[CNT_W*i +: CNT_W]),
      .abort_cnt    (AbortCnt[CNT_W*i +: CNT_W])
    );

    assign LinkState[2*i +: 2] = state;
  end

endmodule

// File: doc/hdlc_line_monitor.md
Name: hdlc_line_monitor

Overview:
- Synthesizable, parametrised multi-channel HDLC bit-stream monitor.
- Per channel it tracks flag sync, detects flags, aborts and idle, and checks zero insertion on transmitted data.
- Keeps saturating per-channel error and abort counters for the status register file.
- Sits beside the Rx/Tx datapaths; one instance serves NUM_CH serial lines.

Parameters:
- NUM_CH, 1, number of independent serial channels.
- CNT_W, 16, width of each per-channel counter.
- IDLE_LEN, 8, consecutive ones for IdleDetect; legal range 8..15, elaboration error otherwise.
- STUFF_LEN, 5, max ones in a row before an inserted zero is mandatory.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  synchronous, active-high reset.
- Enable  in  NUM_CH  per-channel monitor enable.
- Clear  in  NUM_CH  synchronous per-channel counter clear.
- BitIn  in  NUM_CH  serial bit per channel.
- BitValid  in  NUM_CH  bit strobe; BitIn is sampled only when high.
- ValidFrame  in  NUM_CH  high only during stuffed payload+FCS bits, never during flags.
- AbortedTrans  in  NUM_CH  transmitter is deliberately sending an abort.
- FlagDetect  out  NUM_CH  one-Clk pulse per flag.
- AbortDetect  out  NUM_CH  one-Clk pulse per abort.
- IdleDetect  out  NUM_CH  level: idle line.
- StuffErr  out  NUM_CH  one-Clk pulse per zero-insertion violation.
- LinkState  out  2*NUM_CH  per channel: 0 HUNT, 1 SYNC, 2 FRAME.
- ErrCnt  out  CNT_W*NUM_CH  saturating count of StuffErr pulses.
- AbortCnt  out  CNT_W*NUM_CH  saturating count of AbortDetect pulses.

Behaviour:
- Reset (Rst=1 at a Clk edge) clears everything for all channels:
  - all outputs 0, LinkState=HUNT;
  - shift registers 0, ones-run counters 0, pipeline registers 0.
- Reset mid-frame discards the frame; no pulses are issued for bits sampled in the reset cycle.
- Channels are fully independent; all per-channel logic is identical.
- Sampling on a Clk edge with Enable=1 and BitValid=1:
  - shift8 <= {shift8[6:0], BitIn};
  - ones_run <= BitIn ? sat(ones_run+1, 15) : 0.
- BitValid=0: shift8 and ones_run hold; the output pipeline still advances every Clk.
- Enable=0: LinkState forced to HUNT, ones_run and shift8 cleared, FlagDetect/AbortDetect/StuffErr/IdleDetect forced 0. Counters hold.
- Flag: the bit just sampled completes 0111_1110 in shift8.
  - FlagDetect pulses exactly 2 Clk after the sampling edge of the closing 0 (stage 1 compare, stage 2 output register).
  - Pulses with BitValid gaps keep the 2-Clk latency.
- Abort: ones_run reaches 7 while LinkState is SYNC or FRAME.
  - AbortDetect pulses 2 Clk after the sampling edge of the 7th one.
  - AbortCnt +1 on the same edge the pulse is registered.
  - LinkState returns to HUNT.
  - 7 ones in HUNT is not an abort.
- Idle: IdleDetect goes high 2 Clk after the sample making ones_run >= IDLE_LEN, stays high while ones_run >= IDLE_LEN, and drops 2 Clk after the next sampled 0.
- Stuffing check, per sampled bit with ValidFrame=1 and AbortedTrans=0:
  - BitIn=1 with ones_run==STUFF_LEN (before increment) is a violation.
  - StuffErr pulses 2 Clk later; ErrCnt +1.
  - Only one StuffErr per run of ones; re-armed by the next 0.
- LinkState transitions, evaluated on sampled bits:
  - HUNT -> SYNC on flag.
  - SYNC -> SYNC on flag (back-to-back/shared-zero flags allowed).
  - SYNC -> FRAME when 8 bits have been sampled since the last flag without a new flag.
  - FRAME -> SYNC on flag (end of frame).
  - SYNC/FRAME -> HUNT on abort.
  - Any state -> HUNT on Enable=0.
- Simultaneous events on one sample:
  - abort and StuffErr may both fire (7th one after a violation at the 6th); both counted.
  - flag and abort cannot coincide.
- Counters:
  - saturate at 2^CNT_W-1, no wrap.
  - Clear wins over an increment in the same cycle; the result is 0.
  - Rst clears counters; Enable=0 does not.

Decomposition:
- Shared package hdlc_mon_pkg holds:
  - typedef enum logic [1:0] link_state_t {HUNT, SYNC, FRAME};
  - FLAG_PATTERN = 8'h7E;
  - ABORT_ONES = 7.
- One sub-module, hdlc_mon_channel, contains all per-channel logic (shift register, ones counter, FSM, 2-stage output pipeline, two saturating counters).
- The top level is a generate loop over NUM_CH plus port packing.

Test Plan:
- NUM_CH=1, Rst, then bits 0,1,1,1,1,1,1,0 on consecutive Clk with BitValid=1 -> FlagDetect=1 exactly 2 Clk after the closing 0, LinkState HUNT->SYNC.
- Flag, 16 data bits, then 0 followed by 7 ones -> LinkState FRAME, then AbortDetect pulse 2 Clk after the 7th one, AbortCnt=1, LinkState=HUNT.
- ValidFrame=1, AbortedTrans=0, bits 0,1,1,1,1,1,1 -> StuffErr pulse 2 Clk after the 6th one, ErrCnt=1. Repeat with AbortedTrans=1 -> no StuffErr, ErrCnt unchanged.
- 20 consecutive ones, IDLE_LEN=8 -> IdleDetect rises 2 Clk after the 8th one; a single 0 -> IdleDetect falls 2 Clk later.
- CNT_W=2: five violations -> ErrCnt saturates at 3. Clear asserted together with a 6th violation -> ErrCnt=0.
- NUM_CH=4: flag on ch2 with BitValid toggling every other Clk, Rst asserted mid-frame on ch0 -> only ch2 FlagDetect fires; after Rst all outputs 0 and all LinkState=HUNT.
